// File: rtl/command_issuer_if.sv
// Host-side push channel and controller-side issue outputs of the command issuer.
interface command_issuer_if #(
    parameter int CMD_W = 12
);
    logic             push_valid;
    logic [CMD_W-1:0] push_cmd;
    logic             push_ready;
    logic [CMD_W-1:0] command;
    logic             syscall;
    logic             busy;
    logic             empty;
    logic             full;
    logic [15:0]      issued_count;

    modport master (
        output push_valid, push_cmd,
        input  push_ready, command, syscall, busy, empty, full, issued_count
    );

    modport slave (
        input  push_valid, push_cmd,
        output push_ready, command, syscall, busy, empty, full, issued_count
    );
endinterface

// File: rtl/command_issuer.sv
// Command FIFO plus issue pacer: pops one command per controller state sequence and
// strobes syscall, spacing strobes by the controller's fixed latency for that opcode.
module command_issuer #(
    parameter int         DEPTH    = 4,
    parameter int         CMD_W    = 12,
    parameter logic [2:0] OP_CAS   = 3'b111,
    parameter int         NORM_GAP = 4,
    parameter int         CAS_GAP  = 5
) (
    input  logic           clk,
    input  logic           rst,
    command_issuer_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int MAX_GAP = (CAS_GAP > NORM_GAP) ? CAS_GAP : NORM_GAP;
    localparam int HOLD_W  = $clog2(MAX_GAP + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [CMD_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    state_t            state;
    logic [HOLD_W-1:0] holdoff;
    logic [CMD_W-1:0]  command_q;
    logic              syscall_q;
    logic [15:0]       issued_q;
    logic [CMD_W-1:0]  head;
    logic              full;
    logic              empty;
    logic              push_fire;
    logic              pop_fire;

    // Holdoff counts the non-strobe cycles left before the next issue slot.
    function automatic logic [HOLD_W-1:0] reload(input logic [2:0] op);
        return (op == OP_CAS) ? HOLD_W'(CAS_GAP - 1) : HOLD_W'(NORM_GAP - 1);
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign push_fire = bus.push_valid && !full && !rst;
    assign pop_fire  = !empty && ((state == IDLE) || (holdoff == '0));

    assign bus.push_ready   = !full && !rst;
    assign bus.command      = command_q;
    assign bus.syscall      = syscall_q;
    assign bus.busy         = (state == WAIT);
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.issued_count = issued_q;

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= bus.push_cmd;
    end

    // A full FIFO refuses pushes even when the head is leaving this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            holdoff   <= '0;
            command_q <= '0;
            syscall_q <= 1'b0;
            issued_q  <= '0;
        end else begin
            syscall_q <= 1'b0;
            if (pop_fire) begin
                command_q <= head;
                syscall_q <= 1'b1;
                issued_q  <= issued_q + 16'd1;
                holdoff   <= reload(head[CMD_W-1 -: 3]);
                state     <= WAIT;
            end else if (state == WAIT) begin
                if (holdoff == '0) state <= IDLE;
                else               holdoff <= holdoff - HOLD_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_command_issuer.sv
// Scoreboard bench for command_issuer: accepted pushes queue expected commands,
// a negedge monitor records each syscall strobe with its cycle number.
`timescale 1ns/1ps
module tb_command_issuer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    command_issuer_if #(.CMD_W(12)) bus ();
    command_issuer dut (.clk(clk), .rst(rst), .bus(bus));

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int double_cnt = 0;
    logic prev_sys = 1'b0;
    logic [11:0] exp_q[$];
    logic [11:0] obs_cmd[$];
    int obs_cyc[$];
    int got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.syscall === 1'b1) begin
            obs_cmd.push_back(bus.command);
            obs_cyc.push_back(cyc);
            if (prev_sys) double_cnt <= double_cnt + 1;
        end
        prev_sys <= (bus.syscall === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [11:0] c);
        int t = 0;
        while (bus.push_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        bus.push_valid = 1'b1;
        bus.push_cmd   = c;
        if (bus.push_ready === 1'b1) exp_q.push_back(c);
        @(negedge clk);
        bus.push_valid = 1'b0;
    endtask

    task automatic drain(input int n, input string name);
        int t = 0;
        logic [11:0] g;
        logic [11:0] e;
        while (obs_cmd.size() < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        total_cnt++;
        if (obs_cmd.size() < n)
            $display("FAIL %s_pulses: got %0d pulses, want %0d", name, obs_cmd.size(), n);
        else pass_cnt++;
        got_cyc.delete();
        while (obs_cmd.size() > 0 && exp_q.size() > 0) begin
            g = obs_cmd.pop_front();
            e = exp_q.pop_front();
            got_cyc.push_back(obs_cyc.pop_front());
            total_cnt++;
            if (g !== e) $display("FAIL %s_cmd: got %o, want %o", name, g, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (obs_cmd.size() != 0 || exp_q.size() != 0)
            $display("FAIL %s_leftover: got %0d unmatched pulses / %0d unissued, want 0/0",
                     name, obs_cmd.size(), exp_q.size());
        else pass_cnt++;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(bus.busy === 1'b0 && bus.empty === 1'b1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        total_cnt++;
        if (t >= 100) $display("FAIL wait_idle: busy=%b empty=%b, want 0/1", bus.busy, bus.empty);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_cmd = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.push_ready !== 1'b0) $display("FAIL rst_ready: got %b, want 0", bus.push_ready); else pass_cnt++;
        total_cnt++;
        if (bus.command !== 12'o0) $display("FAIL rst_command: got %o, want 0", bus.command); else pass_cnt++;
        total_cnt++;
        if (bus.syscall !== 1'b0) $display("FAIL rst_syscall: got %b, want 0", bus.syscall); else pass_cnt++;
        total_cnt++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0)
            $display("FAIL rst_flags: got empty=%b full=%b, want 1/0", bus.empty, bus.full);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b, want 0", bus.busy); else pass_cnt++;
        total_cnt++;
        if (bus.issued_count !== 16'd0) $display("FAIL rst_count: got %0d, want 0", bus.issued_count); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.push_ready !== 1'b1) $display("FAIL rst_ready_after: got %b, want 1", bus.push_ready); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_single();
        int acc;
        push(12'o0127);
        acc = cyc;
        total_cnt++;
        if (bus.syscall !== 1'b0) $display("FAIL single_nobypass: got %b, want 0", bus.syscall); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.syscall !== 1'b1) $display("FAIL single_syscall: got %b, want 1", bus.syscall); else pass_cnt++;
        total_cnt++;
        if (bus.command !== 12'o0127) $display("FAIL single_command: got %o, want 0127", bus.command); else pass_cnt++;
        total_cnt++;
        if (bus.issued_count !== 16'd1) $display("FAIL single_count: got %0d, want 1", bus.issued_count); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (bus.busy !== 1'b1) $display("FAIL single_busy%0d: got %b, want 1", i, bus.busy); else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (bus.syscall !== 1'b0) $display("FAIL single_strobe%0d: got %b, want 0", i, bus.syscall); else pass_cnt++;
        end
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL single_idle: got busy=%b, want 0", bus.busy); else pass_cnt++;
        drain(1, "single");
        if (got_cyc.size() == 1) begin
            total_cnt++;
            if (got_cyc[0] != acc + 1) $display("FAIL single_latency: got %0d, want %0d", got_cyc[0] - acc, 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        wait_idle();
        push(12'o0127);
        push(12'o2127);
        push(12'o1017);
        drain(3, "b2b");
        if (got_cyc.size() == 3) begin
            for (int i = 1; i < 3; i++) begin
                total_cnt++;
                if (got_cyc[i] - got_cyc[i-1] != 4)
                    $display("FAIL b2b_gap%0d: got %0d, want 4", i, got_cyc[i] - got_cyc[i-1]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_cas();
        int want[3] = '{5, 4, 5};
        wait_idle();
        push(12'o7123);
        push(12'o0127);
        push(12'o7456);
        push(12'o0127);
        drain(4, "cas");
        if (got_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                total_cnt++;
                if (got_cyc[i] - got_cyc[i-1] != want[i-1])
                    $display("FAIL cas_gap%0d: got %0d, want %0d", i, got_cyc[i] - got_cyc[i-1], want[i-1]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_full();
        logic [11:0] cmds[6] = '{12'o0100, 12'o0211, 12'o1322, 12'o2433, 12'o3544, 12'o4655};
        int i = 0;
        int t = 0;
        int rejects = 0;
        int fullpop = 0;
        logic was_full = 1'b0;
        wait_idle();
        while (i < 6 && t < 100) begin
            bus.push_valid = 1'b1;
            bus.push_cmd   = cmds[i];
            total_cnt++;
            if (bus.push_ready !== ~bus.full)
                $display("FAIL full_ready: got ready=%b with full=%b, want ready=%b", bus.push_ready, bus.full, ~bus.full);
            else pass_cnt++;
            if (was_full && bus.syscall === 1'b1) begin
                fullpop++;
                total_cnt++;
                if (bus.full !== 1'b0) $display("FAIL full_pop_reject: got full=%b, want 0", bus.full); else pass_cnt++;
            end
            if (bus.push_ready === 1'b1) begin
                exp_q.push_back(cmds[i]);
                i++;
            end else rejects++;
            was_full = bus.full;
            @(negedge clk);
            t++;
        end
        bus.push_valid = 1'b0;
        total_cnt++;
        if (rejects == 0) $display("FAIL full_rejects: got %0d, want >0", rejects); else pass_cnt++;
        total_cnt++;
        if (fullpop == 0) $display("FAIL full_pop_seen: got %0d, want >0", fullpop); else pass_cnt++;
        drain(6, "full");
        if (got_cyc.size() == 6) begin
            for (int k = 1; k < 6; k++) begin
                total_cnt++;
                if (got_cyc[k] - got_cyc[k-1] != 4)
                    $display("FAIL full_gap%0d: got %0d, want 4", k, got_cyc[k] - got_cyc[k-1]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] g;
        logic [11:0] e;
        wait_idle();
        push(12'o0201);
        push(12'o0202);
        push(12'o0203);
        push(12'o0204);
        total_cnt++;
        if (obs_cmd.size() != 1 || bus.busy !== 1'b1)
            $display("FAIL mid_pre: got %0d pulses busy=%b, want 1 pulse busy=1", obs_cmd.size(), bus.busy);
        else pass_cnt++;
        if (obs_cmd.size() > 0) begin
            g = obs_cmd.pop_front();
            e = exp_q.pop_front();
            void'(obs_cyc.pop_front());
            total_cnt++;
            if (g !== e) $display("FAIL mid_first_cmd: got %o, want %o", g, e); else pass_cnt++;
        end
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.syscall !== 1'b0 || bus.empty !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL mid_reset: got syscall=%b empty=%b busy=%b, want 0/1/0", bus.syscall, bus.empty, bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.issued_count !== 16'd0) $display("FAIL mid_count: got %0d, want 0", bus.issued_count); else pass_cnt++;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        total_cnt++;
        if (obs_cmd.size() != 0) $display("FAIL mid_no_pulse: got %0d pulses, want 0", obs_cmd.size()); else pass_cnt++;
        obs_cmd.delete();
        obs_cyc.delete();
    endtask

    task automatic test_wrap();
        wait_idle();
        force dut.issued_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.issued_q;
        @(negedge clk);
        total_cnt++;
        if (bus.issued_count !== 16'hFFFF) $display("FAIL wrap_preset: got %h, want ffff", bus.issued_count); else pass_cnt++;
        push(12'o3456);
        drain(1, "wrap");
        total_cnt++;
        if (bus.issued_count !== 16'h0000) $display("FAIL wrap_count: got %h, want 0000", bus.issued_count); else pass_cnt++;
    endtask

    task automatic test_no_double();
        wait_idle();
        total_cnt++;
        if (double_cnt != 0) $display("FAIL no_double: got %0d double strobes, want 0", double_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_cas();
        test_full();
        test_reset_mid();
        test_wrap();
        test_no_double();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
